delay1_delayprog: RTL and testbench

Programmable, multi-channel digital successor to the fixed single-edge RC delay cells used in the softstart and stepdown control paths. Each of NCH channels synchronises an asynchronous input, then applies an inertial, clock-counted delay to the selected edge(s) before driving its output. Delay length and edge mode are set per channel at run time, replacing one-off generated delay cells with a single reusable block clocked from the local control clock.

---
 rtl/delay1_pkg.sv | 39 +++
 rtl/delay1_chan.sv | 105 ++++++++++
 rtl/delay1_delayprog.sv | 58 +++++
 tb/tb_delay1_delayprog.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay1_pkg.sv
// Shared types and limits for the programmable delay cell.
//   edge_mode_e   : per-channel edge mode (rise / fall / both / pass-through)
//   chan_state_e  : per-channel FSM state (idle / counting)
//   edge_qualifies: true when a change of the synchronised input to level s
//                   is an edge that must be delayed under mode m
package delay1_pkg;

  localparam int NCH_MIN  = 1;
  localparam int NCH_MAX  = 16;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int CW_MIN   = 1;
  localparam int CW_MAX   = 32;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_PASS = 2'b11
  } edge_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } chan_state_e;

  // s is the new level the output is about to move to.
  function automatic logic edge_qualifies(input edge_mode_e m, input logic s);
    logic q;
    case (m)
      EDGE_RISE: q = s;
      EDGE_FALL: q = ~s;
      EDGE_BOTH: q = 1'b1;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/delay1_chan.sv
// One delay channel: input synchroniser, IDLE/COUNT FSM, down-counter and
// output flop. Implements an inertial delay: a transition on the synchronised
// input reaches the output only if it is held for dly+2 cycles.
// Ports:
//   clk, rst   clock, async active-high reset
//   i          raw asynchronous input
//   dft        delay-free bypass: o = i combinationally, FSM held idle
//   en         enable; 0 makes every transition pass after one cycle
//   dly        delay in clk cycles, sampled only when a count starts
//   mode       edge mode (see delay1_pkg::edge_mode_e)
//   o          delayed output
//   busy       a transition is pending (FSM counting)
module delay1_chan
  import delay1_pkg::*;
#(
  parameter int   CW          = 12,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i,
  input  logic          dft,
  input  logic          en,
  input  logic [CW-1:0] dly,
  input  logic [1:0]    mode,
  output logic          o,
  output logic          busy
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  chan_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   s;
  edge_mode_e             mode_e;

  assign s      = sync_q[SYNC_STAGES-1];
  assign mode_e = edge_mode_e'(mode);

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    if (dft) begin
      // Synchroniser keeps running so the FSM resumes against a fresh s.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s != o_q) begin
            if (en && edge_qualifies(mode_e, s)) begin
              state_d = ST_COUNT;
              cnt_d   = dly;
            end else begin
              o_d = s;
            end
          end
        end
        ST_COUNT: begin
          if (!en) begin
            o_d     = s;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (s == o_q) begin
            // Input reverted before the delay expired: swallow the glitch.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            o_d     = s;
            state_d = ST_IDLE;
          end else begin
            // Zero is tested first, so the counter never wraps.
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= RST_VAL;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

  assign o    = dft ? i : o_q;
  assign busy = (state_q == ST_COUNT) && !dft;

endmodule

// File: rtl/delay1_delayprog.sv
// Programmable multi-channel inertial delay. NCH independent channels, each
// synchronising its input and delaying the selected edge(s) by a run-time
// number of CELCLK cycles.
// Optional feature macro: CEL_DELAY_DFT_EN adds input CELDFT, which forces
// o = i combinationally on all channels for delay-free scan observation.
// Ports:
//   CELCLK  control clock          CELRST  async active-high reset
//   i       raw channel inputs     dly     per-channel delay, ch n at [n*CW +: CW]
//   mode    per-channel edge mode, ch n at [2n +: 2]
//   en      global enable (0 = bypass all delays)
//   o       delayed outputs        busy    per-channel pending transition
module delay1_delayprog
  import delay1_pkg::*;
#(
  parameter int   NCH         = 4,
  parameter int   CW          = 12,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic              CELCLK,
  input  logic              CELRST,
`ifdef CEL_DELAY_DFT_EN
  input  logic              CELDFT,
`endif
  input  logic [NCH-1:0]    i,
  input  logic [NCH*CW-1:0] dly,
  input  logic [2*NCH-1:0]  mode,
  input  logic              en,
  output logic [NCH-1:0]    o,
  output logic [NCH-1:0]    busy
);

  logic dft;
`ifdef CEL_DELAY_DFT_EN
  assign dft = CELDFT;
`else
  assign dft = 1'b0;
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    delay1_chan #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VAL)
    ) u_chan (
      .clk  (CELCLK),
      .rst  (CELRST),
      .i    (i[n]),
      .dft  (dft),
      .en   (en),
      .dly  (dly[n*CW +: CW]),
      .mode (mode[2*n +: 2]),
      .o    (o[n]),
      .busy (busy[n])
    );
  end

endmodule

// File: tb/tb_delay1_delayprog.sv
module tb_delay1_delayprog;
  localparam int NCH  = 4;
  localparam int CW   = 12;
  localparam int SYNC = 2;

  logic              CELCLK = 1'b0;
  logic              CELRST = 1'b1;
  logic              CELDFT = 1'b0;
  logic [NCH-1:0]    i      = '0;
  logic [NCH*CW-1:0] dly    = '0;
  logic [2*NCH-1:0]  mode   = '1;
  logic              en     = 1'b1;
  logic [NCH-1:0]    o;
  logic [NCH-1:0]    busy;

  int checks = 0;
  int errors = 0;

  always #5 CELCLK = ~CELCLK;

  delay1_delayprog #(
    .NCH(NCH), .CW(CW), .SYNC_STAGES(SYNC), .RST_VAL(1'b0)
  ) dut (
    .CELCLK (CELCLK),
    .CELRST (CELRST),
`ifdef CEL_DELAY_DFT_EN
    .CELDFT (CELDFT),
`endif
    .i      (i),
    .dly    (dly),
    .mode   (mode),
    .en     (en),
    .o      (o),
    .busy   (busy)
  );

  task automatic tick();
    @(posedge CELCLK);
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Edges from now until o[ch]==tgt (-1 if the bound expires), plus busy samples seen.
  task automatic wait_o(input int ch, input logic tgt, input int bound,
                        output int edges, output int bcnt);
    int k;
    k = 0; bcnt = 0; edges = -1;
    while (k < bound) begin
      tick();
      k++;
      if (busy[ch]) bcnt++;
      if (o[ch] === tgt) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    CELRST = 1'b1; i = '0; en = 1'b1; dly = '0; mode = '1;
    #1;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL reset_o got %b expected %b", o, 4'b0000); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b expected %b", busy, 4'b0000); end
    settle(2);
    CELRST = 1'b0;
    settle(5);
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL release_o got %b expected %b", o, 4'b0000); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL release_busy got %b expected %b", busy, 4'b0000); end
  endtask

  task automatic test_rise();
    int e, b;
    mode[1:0] = 2'b00; dly[0 +: CW] = 12'd10;
    i[0] = 1'b1;
    wait_o(0, 1'b1, 40, e, b);
    checks++; if (e !== SYNC + 12) begin errors++; $display("FAIL rise_lat got %0d expected %0d", e, SYNC + 12); end
    checks++; if (b !== 11) begin errors++; $display("FAIL rise_busy got %0d expected %0d", b, 11); end
    i[0] = 1'b0;
    wait_o(0, 1'b0, 40, e, b);
    checks++; if (e !== SYNC + 1) begin errors++; $display("FAIL rise_nq_fall got %0d expected %0d", e, SYNC + 1); end
    checks++; if (b !== 0) begin errors++; $display("FAIL rise_nq_busy got %0d expected %0d", b, 0); end
    settle(3);
  endtask

  task automatic test_fall();
    int e, b;
    mode[1:0] = 2'b01; dly[0 +: CW] = 12'd5;
    i[0] = 1'b1;
    wait_o(0, 1'b1, 40, e, b);
    checks++; if (e !== SYNC + 1) begin errors++; $display("FAIL fall_nq_rise got %0d expected %0d", e, SYNC + 1); end
    settle(3);
    i[0] = 1'b0;
    wait_o(0, 1'b0, 40, e, b);
    checks++; if (e !== SYNC + 7) begin errors++; $display("FAIL fall_lat got %0d expected %0d", e, SYNC + 7); end
    checks++; if (b !== 6) begin errors++; $display("FAIL fall_busy got %0d expected %0d", b, 6); end
    settle(3);
  endtask

  task automatic run_pulse(input int width, input int nedges, output int rise_e,
                           output int fall_e, output int hi, output int bsy);
    rise_e = 0; fall_e = 0; hi = 0; bsy = 0;
    i[0] = 1'b1;
    for (int k = 1; k <= nedges; k++) begin
      tick();
      if (o[0]) hi++;
      if (busy[0]) bsy++;
      if (o[0] && rise_e == 0) rise_e = k;
      if (!o[0] && rise_e != 0 && fall_e == 0) fall_e = k;
      if (k == width) i[0] = 1'b0;
    end
  endtask

  task automatic test_both_pulse();
    int r, f, h, b;
    mode[1:0] = 2'b10; dly[0 +: CW] = 12'd3;
    run_pulse(4, 20, r, f, h, b);
    checks++; if (h !== 0) begin errors++; $display("FAIL glitch_o_high got %0d expected %0d", h, 0); end
    checks++; if (b !== 4) begin errors++; $display("FAIL glitch_busy got %0d expected %0d", b, 4); end
    run_pulse(6, 25, r, f, h, b);
    checks++; if (r !== SYNC + 5) begin errors++; $display("FAIL pulse_rise got %0d expected %0d", r, SYNC + 5); end
    checks++; if (f !== 6 + SYNC + 5) begin errors++; $display("FAIL pulse_fall got %0d expected %0d", f, 6 + SYNC + 5); end
    checks++; if (h !== 6) begin errors++; $display("FAIL pulse_width got %0d expected %0d", h, 6); end
    checks++; if (b !== 8) begin errors++; $display("FAIL pulse_busy got %0d expected %0d", b, 8); end
    settle(3);
  endtask

  task automatic test_mode_change();
    int e, b;
    mode[7:6] = 2'b00; dly[3*CW +: CW] = 12'd6;
    i[3] = 1'b1;
    settle(4);
    checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL modechg_busy got %b expected %b", busy[3], 1'b1); end
    mode[7:6] = 2'b11;
    wait_o(3, 1'b1, 40, e, b);
    checks++; if (e !== SYNC + 8 - 4) begin errors++; $display("FAIL modechg_lat got %0d expected %0d", e, SYNC + 8 - 4); end
    i[3] = 1'b0;
    wait_o(3, 1'b0, 40, e, b);
    checks++; if (e !== SYNC + 1) begin errors++; $display("FAIL modechg_pass got %0d expected %0d", e, SYNC + 1); end
    settle(3);
  endtask

  task automatic test_dly_extremes();
    int e, b, e1, e2, e3, b1, other;
    mode = 8'b11_11_00_11; dly[1*CW +: CW] = 12'd0;
    i[1] = 1'b1;
    wait_o(1, 1'b1, 40, e, b);
    checks++; if (e !== SYNC + 2) begin errors++; $display("FAIL dly0_lat got %0d expected %0d", e, SYNC + 2); end
    checks++; if (b !== 1) begin errors++; $display("FAIL dly0_busy got %0d expected %0d", b, 1); end
    i[1] = 1'b0;
    settle(6);
    dly[1*CW +: CW] = 12'd4095;
    e1 = -1; e2 = -1; e3 = -1; b1 = 0; other = 0;
    i[1] = 1'b1; i[2] = 1'b1;
    for (int k = 1; k <= 4200; k++) begin
      tick();
      if (busy[1]) b1++;
      if (o[1] && e1 < 0) e1 = k;
      if (o[2] && e2 < 0) e2 = k;
      if (o[3] && e3 < 0) e3 = k;
      if (o[0] || busy[0] || busy[2] || busy[3]) other++;
      if (k == 100) i[3] = 1'b1;
    end
    checks++; if (e1 !== SYNC + 4097) begin errors++; $display("FAIL dlymax_lat got %0d expected %0d", e1, SYNC + 4097); end
    checks++; if (b1 !== 4096) begin errors++; $display("FAIL dlymax_busy got %0d expected %0d", b1, 4096); end
    checks++; if (e2 !== SYNC + 1) begin errors++; $display("FAIL indep_ch2 got %0d expected %0d", e2, SYNC + 1); end
    checks++; if (e3 !== 100 + SYNC + 1) begin errors++; $display("FAIL indep_ch3 got %0d expected %0d", e3, 100 + SYNC + 1); end
    checks++; if (other !== 0) begin errors++; $display("FAIL indep_other got %0d expected %0d", other, 0); end
    i[3:1] = 3'b000;
    settle(6);
  endtask

  task automatic test_en_off();
    int e, b;
    mode[1:0] = 2'b00; dly[0 +: CW] = 12'd100;
    i[0] = 1'b1;
    settle(20);
    checks++; if (busy[0] !== 1'b1 || o[0] !== 1'b0) begin errors++; $display("FAIL en_pre got busy=%b o=%b expected busy=1 o=0", busy[0], o[0]); end
    en = 1'b0;
    tick();
    checks++; if (o[0] !== 1'b1) begin errors++; $display("FAIL en_drop_o got %b expected %b", o[0], 1'b1); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL en_drop_busy got %b expected %b", busy[0], 1'b0); end
    mode[1:0] = 2'b01;
    i[0] = 1'b0;
    wait_o(0, 1'b0, 40, e, b);
    checks++; if (e !== SYNC + 1) begin errors++; $display("FAIL en_bypass_lat got %0d expected %0d", e, SYNC + 1); end
    checks++; if (b !== 0) begin errors++; $display("FAIL en_bypass_busy got %0d expected %0d", b, 0); end
    en = 1'b1;
    settle(3);
  endtask

  task automatic test_rst_mid();
    int e, b;
    mode[1:0] = 2'b01; dly[0 +: CW] = 12'd100;
    i[0] = 1'b1;
    wait_o(0, 1'b1, 40, e, b);
    settle(3);
    i[0] = 1'b0;
    settle(SYNC + 51);
    checks++; if (busy[0] !== 1'b1 || o[0] !== 1'b1) begin errors++; $display("FAIL rst_pre got busy=%b o=%b expected busy=1 o=1", busy[0], o[0]); end
    #2 CELRST = 1'b1;
    #1;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL rst_mid_o got %b expected %b", o, 4'b0000); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rst_mid_busy got %b expected %b", busy, 4'b0000); end
    settle(2);
    CELRST = 1'b0;
    settle(5);
    checks++; if (o !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL rst_post got o=%b busy=%b expected 0000 0000", o, busy); end
  endtask

`ifdef CEL_DELAY_DFT_EN
  task automatic test_dft();
    int e, b;
    mode = '1;
    CELDFT = 1'b1;
    i = 4'b1011;
    #1;
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL dft_o1 got %b expected %b", o, 4'b1011); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL dft_busy got %b expected %b", busy, 4'b0000); end
    i = 4'b0110;
    #1;
    checks++; if (o !== 4'b0110) begin errors++; $display("FAIL dft_o2 got %b expected %b", o, 4'b0110); end
    settle(4);
    CELDFT = 1'b0;
    #1;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL dft_exit_hold got %b expected %b", o, 4'b0000); end
    tick();
    checks++; if (o !== 4'b0110) begin errors++; $display("FAIL dft_exit_resume got %b expected %b", o, 4'b0110); end
    i = '0;
    settle(5);
    mode[1:0] = 2'b00; dly[0 +: CW] = 12'd3;
    i[0] = 1'b1;
    wait_o(0, 1'b1, 40, e, b);
    checks++; if (e !== SYNC + 5) begin errors++; $display("FAIL dft_after_lat got %0d expected %0d", e, SYNC + 5); end
    i[0] = 1'b0;
    settle(5);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_both_pulse();
    test_mode_change();
    test_dly_extremes();
    test_en_off();
    test_rst_mid();
`ifdef CEL_DELAY_DFT_EN
    test_dft();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
